lock_reset_seq: RTL

//  Sits directly downstream of the system PLL, in the 48 MHz clk domain. Qualifies the asynchronous
//  PLL lock flag and sequences sys_reset, then cpu_reset. Generates single-cycle clock enables
//  (pixel, CPU, CPU anti-phase) so core logic runs on one clock. Any lock loss re-asserts every

---
 rtl/lock_reset_seq_pkg.sv | 21 ++
 rtl/lock_reset_seq_if.sv | 26 ++
 rtl/lock_reset_seq_ce_div.sv | 45 ++++
 rtl/lock_reset_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/lock_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL-lock reset sequencer.
package lock_seq_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    SYS  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int LOCK_HOLD_DEF = 1024;
  localparam int CPU_DELAY_DEF = 64;
  localparam int DIV_PIX_DEF   = 8;
  localparam int DIV_CPU_DEF   = 12;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lock_reset_seq_if.sv
// Lock input, reset outputs, clock enables and FSM state of the reset sequencer.
interface lock_reset_seq_if;
  import lock_seq_pkg::*;

  logic   pll_locked;
  logic   sw_reset;
  logic   sys_reset;
  logic   cpu_reset;
  logic   ce_pix;
  logic   ce_cpu;
  logic   ce_cpu_n;
  logic   ready;
  state_t state;

  // No valid/ready transfers here: ready is a plain level meaning "sequence complete, in RUN".
  modport master (
    output pll_locked, sw_reset,
    input  sys_reset, cpu_reset, ce_pix, ce_cpu, ce_cpu_n, ready, state
  );

  modport slave (
    input  pll_locked, sw_reset,
    output sys_reset, cpu_reset, ce_pix, ce_cpu, ce_cpu_n, ready, state
  );

endinterface

// File: rtl/lock_reset_seq_ce_div.sv
// Modulo-DIV counter with synchronous clear; registered pulses at the terminal
// count and at count PHASE.
module ce_div
  import lock_seq_pkg::*;
#(
  parameter int DIV   = 8,
  parameter int PHASE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_pulse,
  output logic o_phase
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] PH   = W'(PHASE);

  logic [W-1:0] r_cnt;
  logic         r_pulse;
  logic         r_phase;

  // Pulses are registered one edge after the compare, so the first pulse
  // lands exactly DIV edges after the clear drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_phase <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_pulse <= (r_cnt == LAST);
      r_phase <= (r_cnt == PH);
    end
  end

  assign o_pulse = r_pulse;
  assign o_phase = r_phase;

endmodule

// File: rtl/lock_reset_seq.sv
// Qualifies the PLL lock flag, sequences sys_reset then cpu_reset, and
// generates the pixel/CPU clock enables for the 48 MHz domain.
module lock_reset_seq
  import lock_seq_pkg::*;
#(
  parameter int LOCK_HOLD = LOCK_HOLD_DEF,
  parameter int CPU_DELAY = CPU_DELAY_DEF,
  parameter int DIV_PIX   = DIV_PIX_DEF,
  parameter int DIV_CPU   = DIV_CPU_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  lock_reset_seq_if.slave   bus
);

  localparam int HOLD_W = cnt_w(LOCK_HOLD);
  localparam int DLY_W  = cnt_w(CPU_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(CPU_DELAY - 1);

  logic [1:0]        r_sync;
  logic              w_lk;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [DLY_W-1:0]  w_dly_nxt;
  logic              w_run_en;
  logic              w_pix_pulse;
  logic              w_cpu_pulse;
  logic              w_cpu_half;
  logic              w_unused_pix_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], bus.pll_locked};
  end

  assign w_lk = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT;
      r_hold_cnt <= '0;
      r_dly_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_dly_cnt  <= w_dly_nxt;
    end
  end

  // Lock loss beats sw_reset, which beats the normal sequence; sw_reset
  // restarts the hold count without waiting for a fresh lock.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_dly_nxt   = r_dly_cnt;
    if (!w_lk) begin
      w_state_nxt = WAIT;
      w_hold_nxt  = '0;
      w_dly_nxt   = '0;
    end else if (bus.sw_reset && (r_state != WAIT)) begin
      w_state_nxt = HOLD;
      w_hold_nxt  = '0;
      w_dly_nxt   = '0;
    end else begin
      case (r_state)
        WAIT: begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = SYS;
            w_hold_nxt  = '0;
            w_dly_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        SYS: begin
          if (r_dly_cnt == DLY_LAST) begin
            w_state_nxt = RUN;
            w_dly_nxt   = '0;
          end else begin
            w_dly_nxt = r_dly_cnt + 1'b1;
          end
        end
        RUN:     ;
        default: ;
      endcase
    end
  end

  assign w_run_en = (r_state == SYS) || (r_state == RUN);

  ce_div #(
    .DIV   (DIV_PIX),
    .PHASE (DIV_PIX / 2 - 1)
  ) u_pix_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_run_en),
    .o_pulse (w_pix_pulse),
    .o_phase (w_unused_pix_phase)
  );

  ce_div #(
    .DIV   (DIV_CPU),
    .PHASE (DIV_CPU / 2 - 1)
  ) u_cpu_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_run_en),
    .o_pulse (w_cpu_pulse),
    .o_phase (w_cpu_half)
  );

  // Gating by state kills a pulse already in the flop when the FSM drops out of SYS/RUN.
  assign bus.ce_pix    = w_pix_pulse & w_run_en;
  assign bus.ce_cpu    = w_cpu_pulse & w_run_en;
  assign bus.ce_cpu_n  = w_cpu_half & w_run_en;
  assign bus.sys_reset = (r_state == WAIT) || (r_state == HOLD);
  assign bus.cpu_reset = (r_state != RUN);
  assign bus.ready     = (r_state == RUN);
  assign bus.state     = r_state;

endmodule
